ph_fifo_n: RTL and testbench
============================

// Module: ph_fifo_n
// PURPOSE
//  Parametrised parasite-to-host data FIFO for Tube register 3 (block transfers).
//  Generalises the fixed 2-byte register to DEPTH entries of WIDTH bits.
//  Provides a one-entry latch mode and a DEPTH-entry block mode with fill/drain hysteresis.
//  Sits between the parasite data-register decode and the host bus mux; single clock domain.
// PARAMETERS
//  WIDTH        8     data width in bits
//  DEPTH        2     storage entries, 1..64; need not be a power of 2
//  RST_PRELOAD  1     1: reset leaves one entry (RST_DATA) queued, avoiding a spurious PNMI
//  RST_DATA     8'hAA value of the preloaded entry
// PORTS
//  h_phi2                  in   1      clock; all state updates on posedge
//  h_rst                   in   1      asynchronous, active-high reset
//  one_byte_mode           in   1      1: latch mode (V flag); 0: block mode
//  p_wr                    in   1      parasite write strobe, one cycle per entry
//  p_data                  in   WIDTH  parasite write data
//  p_full                  out  1      parasite must not write while high
//  h_rd                    in   1      host read strobe, one cycle per entry
//  h_data                  out  WIDTH  head entry, first-word-fall-through
//  h_data_available        out  1      host may read
//  h_zero_bytes_available  out  1      FIFO holds no entries
//  p_overrun               out  1      [PH_FIFO_ERR_EN only] sticky rejected-write flag
//  p_overrun_clr           in   1      [PH_FIFO_ERR_EN only] clears p_overrun
// BEHAVIOUR
//  State: mem[DEPTH], wr_ptr/rd_ptr (clog2(DEPTH) bits), count (clog2(DEPTH+1) bits), blk_q.
//  Reset: ptrs 0, blk_q 0; count=RST_PRELOAD, mem[0]=RST_DATA, wr_ptr=RST_PRELOAD%DEPTH.
//   Outputs after reset with RST_PRELOAD=1, one_byte_mode=1: p_full=1, h_data_available=1,
//   h_zero_bytes_available=0, h_data=RST_DATA; p_overrun=0.
//  Accept rules: write accepted iff p_wr & !p_full; read pops iff h_rd & h_data_available.
//   Rejected strobes change no state (except p_overrun). Each accepted access: 1 cycle.
//  Pointers increment on accept and wrap DEPTH-1 -> 0; count +1 on write, -1 on pop.
//  Both accepted in one cycle: both happen, count unchanged.
//  Latency: written entry visible on h_data the cycle after the write edge if FIFO was empty.
//  h_data = mem[rd_ptr] always; stale value when empty (not forced).
//  h_zero_bytes_available = (count==0), combinational from count, any mode.
//  One-byte mode: p_full = h_data_available = (count!=0); blk_q held at 0.
//  Block mode: p_full = h_data_available = blk_q.
//   blk_q next: 1 if count_next==DEPTH; 0 if count_next==0; else hold.
//   Host sees nothing until DEPTH entries written; flag then stays up until fully drained.
//   With DEPTH==1 block mode behaves identically to one-byte mode.
//  Mode change mid-operation: flags re-derived immediately from count/blk_q;
//   switching to block mode with 0<count<DEPTH waits for fill;
//   switching to one-byte mode with count>1 drains normally.
//  Reset asserted mid-burst: all state returns to reset values asynchronously.
// CONFIGURATION
//  PH_FIFO_ERR_EN defined: p_overrun set on p_wr & p_full, held until p_overrun_clr or h_rst.
//   Clear wins over a same-cycle set.
//  PH_FIFO_ERR_EN undefined: both ports absent; rejected writes silently dropped.
// STRUCTURE
//  tube_pkg: mode encodings (MODE_ONE_BYTE/MODE_BLOCK), default RST_DATA, clog2 helper.
//  Sub-module ph_fifo_ctrl: pointers, count, blk_q, accept/flag logic.
//  Storage array and h_data mux live in ph_fifo_n.
// TESTING
//  1 Reset, DEPTH=2, preload=1, one-byte -> h_data=8'hAA, p_full=1, avail=1; h_rd -> zero_bytes=1.
//  2 Block, DEPTH=4: write 11,22,33 -> avail=0, p_full=0; write 44 -> both 1;
//    read x4 -> 11,22,33,44, flags 0 after 4th read.
//  3 Block, DEPTH=3 (non-pow2): 3 full fill/drain rounds -> ptr wrap correct, data order kept.
//  4 Block, full, p_wr=1 with 55 -> rejected, FIFO unchanged, p_overrun=1 (ERR_EN);
//    p_overrun_clr -> 0.
//  5 Block, 2 of 4 entries held, switch to one-byte -> avail=1; reads drain 2 entries
//    in order, then zero_bytes=1.
//  6 h_rst asserted after 3 writes, DEPTH=4 -> asynchronous return to reset outputs;
//    old data unreadable.

Source files
------------

// File: rtl/tube_pkg.sv
// Shared encodings, defaults and sizing helper for the Tube parasite-to-host FIFO.
// The optional overrun flag is enabled with the PH_FIFO_ERR_EN macro.
package tube_pkg;

    typedef enum logic {
        MODE_BLOCK    = 1'b0,
        MODE_ONE_BYTE = 1'b1
    } tube_mode_e;

    localparam logic [7:0] RST_DATA_DEF = 8'hAA;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ph_fifo_ctrl.sv
// Pointer, occupancy and hysteresis flag control for ph_fifo_n.
// p_full and h_data_available are the same flag: one-byte mode uses count!=0, block mode uses blk_q.
module ph_fifo_ctrl
    import tube_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int RST_PRELOAD = 1,
    parameter int PTR_W       = clog2(DEPTH),
    parameter int CNT_W       = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             one_byte_mode_i,
    input  logic             p_wr_i,
    input  logic             h_rd_i,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             flag_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             blk_q, blk_d;
    logic             one_byte;
    logic             wr_acc, rd_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign one_byte = (one_byte_mode_i == MODE_ONE_BYTE);
    assign flag_o   = one_byte ? (count_q != '0) : blk_q;
    assign empty_o  = (count_q == '0);
    assign wr_acc   = p_wr_i & ~flag_o;
    assign rd_acc   = h_rd_i & flag_o;
    assign wr_en_o  = wr_acc;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        blk_d    = blk_q;
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        // Block mode: raise only when full, drop only when fully drained.
        if (one_byte)                         blk_d = 1'b0;
        else if (count_d == CNT_W'(DEPTH))    blk_d = 1'b1;
        else if (count_d == '0)               blk_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_W'(RST_PRELOAD % DEPTH);
            rd_ptr_q <= '0;
            count_q  <= CNT_W'(RST_PRELOAD);
            blk_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            blk_q    <= blk_d;
        end
    end

endmodule

// File: rtl/ph_fifo_n.sv
// Parasite-to-host block-transfer FIFO for Tube register 3: DEPTH x WIDTH, first-word-fall-through.
// Define PH_FIFO_ERR_EN to add the sticky p_overrun flag and its p_overrun_clr input.
module ph_fifo_n
    import tube_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter int               RST_PRELOAD = 1,
    parameter logic [WIDTH-1:0] RST_DATA    = WIDTH'(RST_DATA_DEF)
) (
    input  logic             h_phi2,
    input  logic             h_rst,
    input  logic             one_byte_mode,
    input  logic             p_wr,
    input  logic [WIDTH-1:0] p_data,
    output logic             p_full,
    input  logic             h_rd,
    output logic [WIDTH-1:0] h_data,
    output logic             h_data_available,
`ifdef PH_FIFO_ERR_EN
    output logic             p_overrun,
    input  logic             p_overrun_clr,
`endif
    output logic             h_zero_bytes_available
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_en;
    logic             flag;

    ph_fifo_ctrl #(
        .DEPTH       (DEPTH),
        .RST_PRELOAD (RST_PRELOAD)
    ) u_ctrl (
        .clk_i           (h_phi2),
        .rst_i           (h_rst),
        .one_byte_mode_i (one_byte_mode),
        .p_wr_i          (p_wr),
        .h_rd_i          (h_rd),
        .wr_en_o         (wr_en),
        .wr_ptr_o        (wr_ptr),
        .rd_ptr_o        (rd_ptr),
        .flag_o          (flag),
        .empty_o         (h_zero_bytes_available)
    );

    // Entry 0 comes out of reset holding RST_DATA so a preloaded entry reads back correctly.
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        always_ff @(posedge h_phi2 or posedge h_rst) begin
            if (h_rst)
                mem_q[g] <= (g == 0) ? RST_DATA : '0;
            else if (wr_en && (wr_ptr == PTR_W'(g)))
                mem_q[g] <= p_data;
        end
    end

    assign h_data           = mem_q[rd_ptr];
    assign p_full           = flag;
    assign h_data_available = flag;

`ifdef PH_FIFO_ERR_EN
    logic ovr_q;

    always_ff @(posedge h_phi2 or posedge h_rst) begin
        if (h_rst)              ovr_q <= 1'b0;
        else if (p_overrun_clr) ovr_q <= 1'b0;
        else if (p_wr && flag)  ovr_q <= 1'b1;
    end

    assign p_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_ph_fifo_n.sv
// Three ph_fifo_n instances (DEPTH 2, 4, 3) driven by directed and random traffic against a queue model.
module tb_ph_fifo_n;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode  [N];
    logic       wr    [N];
    logic       rd    [N];
    logic       full  [N];
    logic       avail [N];
    logic       zero  [N];
    logic [7:0] din   [N];
    logic [7:0] dout  [N];
`ifdef PH_FIFO_ERR_EN
    logic       ovr     [N];
    logic       ovr_clr [N];
    bit         movr    [N];
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mq   [N][$];
    bit         mblk [N];

    always #5 clk = ~clk;

    function automatic int depth_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : 3;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        ph_fifo_n #(
            .WIDTH       (8),
            .DEPTH       ((g == 0) ? 2 : (g == 1) ? 4 : 3),
            .RST_PRELOAD (1),
            .RST_DATA    (8'hAA)
        ) dut (
            .h_phi2                 (clk),
            .h_rst                  (rst),
            .one_byte_mode          (mode[g]),
            .p_wr                   (wr[g]),
            .p_data                 (din[g]),
            .p_full                 (full[g]),
            .h_rd                   (rd[g]),
            .h_data                 (dout[g]),
            .h_data_available       (avail[g]),
`ifdef PH_FIFO_ERR_EN
            .p_overrun              (ovr[g]),
            .p_overrun_clr          (ovr_clr[g]),
`endif
            .h_zero_bytes_available (zero[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The host-visible flag as the rules define it: occupancy in one-byte mode, hysteresis bit in block mode.
    function automatic bit mflag(input int i);
        return mode[i] ? (mq[i].size() != 0) : mblk[i];
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("full%0d", i),  full[i],  mflag(i));
            chk($sformatf("avail%0d", i), avail[i], mflag(i));
            chk($sformatf("zero%0d", i),  zero[i],  mq[i].size() == 0);
            if (mq[i].size() != 0)
                chk($sformatf("data%0d", i), dout[i], mq[i][0]);
`ifdef PH_FIFO_ERR_EN
            chk($sformatf("ovr%0d", i), ovr[i], movr[i]);
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i]   = {};
            mq[i].push_back(8'hAA);
            mblk[i] = 1'b0;
`ifdef PH_FIFO_ERR_EN
            movr[i] = 1'b0;
`endif
        end
    endtask

    task automatic step();
        bit aw [N];
        bit ar [N];
        for (int i = 0; i < N; i++) begin
            aw[i] = wr[i] && !mflag(i);
            ar[i] = rd[i] && mflag(i);
`ifdef PH_FIFO_ERR_EN
            if (ovr_clr[i])             movr[i] = 1'b0;
            else if (wr[i] && mflag(i)) movr[i] = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ar[i]) void'(mq[i].pop_front());
            if (aw[i]) mq[i].push_back(din[i]);
            if (mode[i])                            mblk[i] = 1'b0;
            else if (mq[i].size() == depth_of(i))   mblk[i] = 1'b1;
            else if (mq[i].size() == 0)             mblk[i] = 1'b0;
            wr[i] = 1'b0;
            rd[i] = 1'b0;
`ifdef PH_FIFO_ERR_EN
            ovr_clr[i] = 1'b0;
`endif
        end
        check_all();
    endtask

    task automatic wr1(input int i, input logic [7:0] d);
        wr[i]  = 1'b1;
        din[i] = d;
        step();
    endtask

    task automatic rd1(input int i);
        rd[i] = 1'b1;
        step();
    endtask

    // Reset asserted between edges; outputs must change before the next clock.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            mode[i] = 1'b1;
            wr[i]   = 1'b0;
            rd[i]   = 1'b0;
            din[i]  = 8'h00;
`ifdef PH_FIFO_ERR_EN
            ovr_clr[i] = 1'b0;
`endif
        end
        model_reset();
        #1;
        check_all();
        chk("rst_data", dout[0], 8'hAA);
        chk("rst_full", full[0], 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        // Drain the preloaded entry everywhere; instance 0 shows zero_bytes afterwards.
        for (int i = 0; i < N; i++) rd[i] = 1'b1;
        step();
        chk("t1_zero", zero[0], 1'b1);

        mode[1] = 1'b0;
        #1 check_all();
        wr1(1, 8'h11);
        wr1(1, 8'h22);
        wr1(1, 8'h33);
        chk("t2_avail3", avail[1], 1'b0);
        chk("t2_full3", full[1], 1'b0);
        wr1(1, 8'h44);
        chk("t2_avail4", avail[1], 1'b1);
        chk("t2_full4", full[1], 1'b1);
        chk("t2_rd0", dout[1], 8'h11); rd1(1);
        chk("t2_rd1", dout[1], 8'h22); rd1(1);
        chk("t2_rd2", dout[1], 8'h33); rd1(1);
        chk("t2_rd3", dout[1], 8'h44); rd1(1);
        chk("t2_drained", avail[1], 1'b0);

        mode[2] = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) wr1(2, 8'($urandom));
            for (int k = 0; k < 3; k++) rd1(2);
        end

        for (int k = 0; k < 4; k++) wr1(1, 8'h60 + 8'(k));
        wr1(1, 8'h55);
        chk("t4_head", dout[1], 8'h60);
`ifdef PH_FIFO_ERR_EN
        chk("t4_ovr", ovr[1], 1'b1);
        ovr_clr[1] = 1'b1;
        step();
        chk("t4_ovr_clr", ovr[1], 1'b0);
`endif
        for (int k = 0; k < 4; k++) rd1(1);

        wr1(1, 8'h71);
        wr1(1, 8'h72);
        chk("t5_blk_wait", avail[1], 1'b0);
        mode[1] = 1'b1;
        #1;
        chk("t5_avail", avail[1], 1'b1);
        check_all();
        rd1(1);
        rd1(1);
        chk("t5_zero", zero[1], 1'b1);

        mode[1] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) wr1(1, 8'h81 + 8'(k));
        mid_reset();
        chk("t6_data", dout[1], 8'hAA);

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(31) == 0) mode[i] = ~mode[i];
                wr[i]  = $urandom_range(1);
                rd[i]  = $urandom_range(1);
                din[i] = 8'($urandom);
`ifdef PH_FIFO_ERR_EN
                ovr_clr[i] = ($urandom_range(7) == 0);
`endif
            end
            #1 check_all();
            if ($urandom_range(199) == 0) begin
                for (int i = 0; i < N; i++) begin
                    wr[i] = 1'b0;
                    rd[i] = 1'b0;
`ifdef PH_FIFO_ERR_EN
                    ovr_clr[i] = 1'b0;
`endif
                end
                mid_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
